// File: rtl/memory_access_stage_pkg.sv
// Shared definitions for the memory access (MA) stage.
//   - default widths and timeout length
//   - load/store opcode constants
//   - MA access FSM state encoding
package memory_access_stage_pkg;

    localparam int DEF_DATA_W    = 16;
    localparam int DEF_ADDR_W    = 8;
    localparam int DEF_REG_IDX_W = 4;
    localparam int DEF_CTRL_W    = 4;
    localparam int DEF_MAX_WAIT  = 15;

    localparam logic [DEF_CTRL_W-1:0] MA_LOAD_OP  = 4'b1100;
    localparam logic [DEF_CTRL_W-1:0] MA_STORE_OP = 4'b1110;

    // IDLE: accepting from EX. WAIT: a memory access is outstanding.
    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } ma_state_e;

endpackage

// File: rtl/memory_access_stage_ma_wait_timer.sv
// Wait-state timer for the MA stage.
//   clk, reset_n : clock, synchronous active-low reset
//   clear        : force the count to zero (has priority over enable)
//   enable       : advance the count by one, saturating at MAX_WAIT
//   expired      : count has reached MAX_WAIT
module ma_wait_timer #(
    parameter int MAX_WAIT = 15
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != CNT_MAX)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == CNT_MAX);

endmodule

// File: rtl/memory_access_stage.sv
// Memory access (MA) pipeline stage between EX and WB.
//   EX side : valid_ex, control_ex, result_ex (address for load/store),
//             reg_data_ex (store data), dest_reg_index_ex, dest_reg_write_en_ex;
//             stall_ma holds EX and everything upstream.
//   Memory  : mem_req/mem_we/mem_addr/mem_wdata out, mem_rdata/mem_ack in;
//             mem_error pulses for one cycle when an access is aborted.
//   WB side : registered valid_ma, control_ma, result_ma, data_ma,
//             dest_reg_index_ma, dest_reg_write_en_ma.
//
// Handshake: mem_req rises on the edge that captures a load/store and stays
// high, with mem_addr/mem_wdata/mem_we held stable, until the cycle in which
// mem_ack=1 is sampled (the access completes on that edge) or the wait timer
// expires (the access is aborted on that edge). mem_ack outside an access is
// ignored.
//
// Timing: the wait counter is zero in the first WAIT cycle and counts every
// WAIT cycle without an ack. After MAX_WAIT such cycles it reads MAX_WAIT;
// an ack in that cycle still completes the access, otherwise it is aborted.
module memory_access_stage
    import memory_access_stage_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int REG_IDX_W = DEF_REG_IDX_W,
    parameter int CTRL_W    = DEF_CTRL_W,
    parameter logic [CTRL_W-1:0] LOAD_OP  = MA_LOAD_OP,
    parameter logic [CTRL_W-1:0] STORE_OP = MA_STORE_OP,
    parameter int MAX_WAIT  = DEF_MAX_WAIT
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 valid_ex,
    input  logic [CTRL_W-1:0]    control_ex,
    input  logic [DATA_W-1:0]    result_ex,
    input  logic [DATA_W-1:0]    reg_data_ex,
    input  logic [REG_IDX_W-1:0] dest_reg_index_ex,
    input  logic                 dest_reg_write_en_ex,
    output logic                 stall_ma,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [DATA_W-1:0]    mem_wdata,
    input  logic [DATA_W-1:0]    mem_rdata,
    input  logic                 mem_ack,
    output logic                 mem_error,
    output logic                 valid_ma,
    output logic [CTRL_W-1:0]    control_ma,
    output logic [DATA_W-1:0]    result_ma,
    output logic [DATA_W-1:0]    data_ma,
    output logic [REG_IDX_W-1:0] dest_reg_index_ma,
    output logic                 dest_reg_write_en_ma
);

    ma_state_e state_q, state_d;

    // Hold registers: the in-flight instruction while EX moves on is not
    // possible (EX is stalled), but EX fields are only trusted on capture.
    logic [CTRL_W-1:0]    hold_ctrl_q,   hold_ctrl_d;
    logic [DATA_W-1:0]    hold_result_q, hold_result_d;
    logic [DATA_W-1:0]    hold_wdata_q,  hold_wdata_d;
    logic [REG_IDX_W-1:0] hold_dest_q,   hold_dest_d;
    logic                 hold_dwe_q,    hold_dwe_d;

    logic mem_req_q,   mem_req_d;
    logic mem_we_q,    mem_we_d;
    logic mem_error_q, mem_error_d;

    logic                 valid_ma_q,   valid_ma_d;
    logic [CTRL_W-1:0]    control_ma_q, control_ma_d;
    logic [DATA_W-1:0]    result_ma_q,  result_ma_d;
    logic [DATA_W-1:0]    data_ma_q,    data_ma_d;
    logic [REG_IDX_W-1:0] dest_idx_ma_q, dest_idx_ma_d;
    logic                 dest_we_ma_q,  dest_we_ma_d;

    logic is_mem;
    logic timer_clear;
    logic timer_enable;
    logic timer_expired;

    assign is_mem = valid_ex && ((control_ex == LOAD_OP) || (control_ex == STORE_OP));

    // Counter sits at zero while idle, so it starts from zero in WAIT.
    assign timer_clear  = (state_q == IDLE);
    assign timer_enable = (state_q == WAIT) && !mem_ack;

    ma_wait_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (timer_clear),
        .enable  (timer_enable),
        .expired (timer_expired)
    );

    always_comb begin
        state_d       = state_q;
        hold_ctrl_d   = hold_ctrl_q;
        hold_result_d = hold_result_q;
        hold_wdata_d  = hold_wdata_q;
        hold_dest_d   = hold_dest_q;
        hold_dwe_d    = hold_dwe_q;
        mem_req_d     = mem_req_q;
        mem_we_d      = mem_we_q;
        mem_error_d   = 1'b0;
        valid_ma_d    = valid_ma_q;
        control_ma_d  = control_ma_q;
        result_ma_d   = result_ma_q;
        data_ma_d     = data_ma_q;
        dest_idx_ma_d = dest_idx_ma_q;
        dest_we_ma_d  = dest_we_ma_q;
        stall_ma      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (is_mem) begin
                    stall_ma      = 1'b1;
                    hold_ctrl_d   = control_ex;
                    hold_result_d = result_ex;
                    hold_wdata_d  = reg_data_ex;
                    hold_dest_d   = dest_reg_index_ex;
                    hold_dwe_d    = dest_reg_write_en_ex;
                    mem_req_d     = 1'b1;
                    mem_we_d      = (control_ex == STORE_OP);
                    valid_ma_d    = 1'b0;
                    dest_we_ma_d  = 1'b0;
                    state_d       = WAIT;
                end else begin
                    valid_ma_d    = valid_ex;
                    control_ma_d  = control_ex;
                    result_ma_d   = result_ex;
                    data_ma_d     = '0;
                    dest_idx_ma_d = dest_reg_index_ex;
                    dest_we_ma_d  = dest_reg_write_en_ex;
                end
            end
            WAIT: begin
                // Ack in the expiry cycle still completes, so it is tested first.
                stall_ma = !mem_ack && !timer_expired;
                if (mem_ack || timer_expired) begin
                    valid_ma_d    = 1'b1;
                    control_ma_d  = hold_ctrl_q;
                    result_ma_d   = hold_result_q;
                    dest_idx_ma_d = hold_dest_q;
                    mem_req_d     = 1'b0;
                    mem_we_d      = 1'b0;
                    state_d       = IDLE;
                    if (mem_ack) begin
                        dest_we_ma_d = hold_dwe_q;
                        data_ma_d    = (hold_ctrl_q == LOAD_OP) ? mem_rdata : '0;
                    end else begin
                        dest_we_ma_d = 1'b0;
                        data_ma_d    = '0;
                        mem_error_d  = 1'b1;
                    end
                end else begin
                    valid_ma_d   = 1'b0;
                    dest_we_ma_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            hold_ctrl_q   <= '0;
            hold_result_q <= '0;
            hold_wdata_q  <= '0;
            hold_dest_q   <= '0;
            hold_dwe_q    <= 1'b0;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_error_q   <= 1'b0;
            valid_ma_q    <= 1'b0;
            control_ma_q  <= '0;
            result_ma_q   <= '0;
            data_ma_q     <= '0;
            dest_idx_ma_q <= '0;
            dest_we_ma_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            hold_ctrl_q   <= hold_ctrl_d;
            hold_result_q <= hold_result_d;
            hold_wdata_q  <= hold_wdata_d;
            hold_dest_q   <= hold_dest_d;
            hold_dwe_q    <= hold_dwe_d;
            mem_req_q     <= mem_req_d;
            mem_we_q      <= mem_we_d;
            mem_error_q   <= mem_error_d;
            valid_ma_q    <= valid_ma_d;
            control_ma_q  <= control_ma_d;
            result_ma_q   <= result_ma_d;
            data_ma_q     <= data_ma_d;
            dest_idx_ma_q <= dest_idx_ma_d;
            dest_we_ma_q  <= dest_we_ma_d;
        end
    end

    assign mem_req              = mem_req_q;
    assign mem_we               = mem_we_q;
    assign mem_addr             = hold_result_q[ADDR_W-1:0];
    assign mem_wdata            = hold_wdata_q;
    assign mem_error            = mem_error_q;
    assign valid_ma             = valid_ma_q;
    assign control_ma           = control_ma_q;
    assign result_ma            = result_ma_q;
    assign data_ma              = data_ma_q;
    assign dest_reg_index_ma    = dest_idx_ma_q;
    assign dest_reg_write_en_ma = dest_we_ma_q;

endmodule
